fb_fifo_push_arb: RTL and testbench

Round-robin push arbiter that shares one `fb_fifo` write port among `NUM_REQ` independent producers. Each producer offers words on a valid/ready handshake; the arbiter selects one per cycle, drives the FIFO `push`/`in` pins, and backpressures every producer whenever the FIFO reports `full`. It sits directly in front of `fb_fifo` and is its only writer.

---
 rtl/fb_fifo_arb_pkg.sv | 19 +
 rtl/fb_rr_pick.sv | 29 ++
 rtl/fb_fifo_push_arb.sv | 150 +++++++++++++++
 tb/tb_fb_fifo_push_arb.sv | 135 +++++++++++++
 4 files changed

// File: rtl/fb_fifo_arb_pkg.sv
// Shared types and limits for the fb_fifo push arbiter and related schedulers.
package fb_fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int NUM_REQ_MIN   = 2;
    localparam int NUM_REQ_MAX   = 16;
    localparam int MAX_BURST_MIN = 1;
    localparam int MAX_BURST_MAX = 256;

    // Width of a requester index; never narrower than one bit.
    function automatic int fb_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fb_rr_pick.sv
// Rotate-priority encoder: first set bit of req_valid at or after ptr, wrapping.
module fb_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    win,
    output logic               any
);

    logic [NUM_REQ-1:0] rot;

    // Rotate so that bit 0 of rot corresponds to producer ptr.
    assign rot = NUM_REQ'({req_valid, req_valid} >> ptr);

    // Scan from the far end down so the lowest rotated position wins.
    always_comb begin
        win = '0;
        any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                any = 1'b1;
                win = ID_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/fb_fifo_push_arb.sv
// Round-robin push arbiter sharing one fb_fifo write port among NUM_REQ producers.
// Optional burst grant is enabled by defining FB_FIFO_ARB_BURST_EN.
//
// state | meaning
// IDLE  | plain round robin from ptr
// BURST | owner keeps the grant while valid, up to MAX_BURST beats
module fb_fifo_push_arb
    import fb_fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int WIDTH     = 32,
    parameter  int MAX_BURST = 4,
    localparam int ID_W      = fb_id_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_push,
    output logic [WIDTH-1:0]         fifo_in,
    output logic [ID_W-1:0]          grant_id
);

    if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
        $error("fb_fifo_push_arb: NUM_REQ out of range");
    end
    if (MAX_BURST < MAX_BURST_MIN || MAX_BURST > MAX_BURST_MAX) begin : g_bad_max_burst
        $error("fb_fifo_push_arb: MAX_BURST out of range");
    end

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] x);
        if (int'(x) >= NUM_REQ - 1) return '0;
        return x + ID_W'(1);
    endfunction

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] pick_ptr;
    logic [ID_W-1:0] pick_win;
    logic            pick_any;
    logic [ID_W-1:0] win;
    logic            have;
    logic            accept;

    fb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (pick_ptr),
        .win       (pick_win),
        .any       (pick_any)
    );

    // full and reset are taken at face value: no beat is accepted under either.
    assign accept = have & ~fifo_full & ~rst;

    // Grant decode and write-port mux; everything reads zero when nothing is pushed.
    always_comb begin
        req_ready = '0;
        fifo_push = accept;
        fifo_in   = '0;
        grant_id  = '0;
        if (accept) begin
            req_ready[win] = 1'b1;
            fifo_in        = req_data[int'(win)*WIDTH +: WIDTH];
            grant_id       = win;
        end
    end

`ifdef FB_FIFO_ARB_BURST_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e       state, state_nxt;
    logic [ID_W-1:0]  owner, owner_nxt;
    logic [ID_W-1:0]  ptr_nxt;
    logic [CNT_W-1:0] burst_cnt, cnt_nxt;
    logic             owner_hold;

    // While bursting, a dropped owner hands off starting just past itself.
    assign owner_hold = (state == BURST) && req_valid[owner];
    assign pick_ptr   = (state == BURST) ? next_id(owner) : ptr;
    assign win        = owner_hold ? owner : pick_win;
    assign have       = owner_hold | pick_any;

    // Burst next-state: extend, finish, or fall back to normal arbitration.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        cnt_nxt   = burst_cnt;
        if (owner_hold) begin
            if (accept) begin
                if (int'(burst_cnt) + 1 >= MAX_BURST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    ptr_nxt   = next_id(owner);
                end else begin
                    cnt_nxt = burst_cnt + CNT_W'(1);
                end
            end
        end else begin
            if (state == BURST) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                ptr_nxt   = next_id(owner);
            end
            if (accept) begin
                if (MAX_BURST > 1) begin
                    state_nxt = BURST;
                    owner_nxt = win;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    ptr_nxt = next_id(win);
                end
            end
        end
    end

    // Burst state and priority pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            burst_cnt <= '0;
            ptr       <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            burst_cnt <= cnt_nxt;
            ptr       <= ptr_nxt;
        end
    end
`else
    assign pick_ptr = ptr;
    assign win      = pick_win;
    assign have     = pick_any;

    // Priority pointer moves past the winner only on an accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= next_id(win);
        end
    end
`endif

endmodule

// File: tb/tb_fb_fifo_push_arb.sv
// Directed bench for fb_fifo_push_arb; covers burst behaviour when FB_FIFO_ARB_BURST_EN is defined.
module tb_fb_fifo_push_arb;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 32;
    localparam int MAX_BURST = 3;
    localparam int ID_W      = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     fifo_full;
    logic                     fifo_push;
    logic [WIDTH-1:0]         fifo_in;
    logic [ID_W-1:0]          grant_id;

    int n_checks = 0;
    int n_pass   = 0;

    fb_fifo_push_arb #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_push (fifo_push),
        .fifo_in   (fifo_in),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Inputs were just driven; let them settle, check, then advance one cycle.
    task automatic expect_beat(input string tag, input int id);
        #1;
        check({tag, " push"},  32'(fifo_push), 32'd1);
        check({tag, " grant"}, 32'(grant_id),  32'(id));
        check({tag, " data"},  fifo_in,        32'hA0 + 32'(id));
        check({tag, " ready"}, 32'(req_ready), 32'(1) << id);
        tick();
    endtask

    task automatic expect_none(input string tag);
        #1;
        check({tag, " push"},  32'(fifo_push), 32'd0);
        check({tag, " grant"}, 32'(grant_id),  32'd0);
        check({tag, " data"},  fifo_in,        32'd0);
        check({tag, " ready"}, 32'(req_ready), 32'd0);
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        fifo_full = 1'b0;
        req_valid = '1;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*WIDTH +: WIDTH] = 32'hA0 + 32'(i);
        tick();

        for (int c = 0; c < 3; c++) expect_none($sformatf("rst%0d", c));
        rst = 1'b0;

`ifndef FB_FIFO_ARB_BURST_EN
        for (int c = 0; c < 8; c++) expect_beat($sformatf("rr%0d", c), c % NUM_REQ);

        req_valid = 4'b1010;
        expect_beat("skip0", 1);
        expect_beat("skip1", 3);
        expect_beat("skip2", 1);
        expect_beat("skip3", 3);
        req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) expect_beat($sformatf("solo%0d", c), 1);

        req_valid = 4'b0000;
        expect_none("novalid");

        req_valid = 4'b1100;
        fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) expect_none($sformatf("full%0d", c));
        fifo_full = 1'b0;
        expect_beat("rel0", 2);
        expect_beat("rel1", 3);

        req_valid = 4'b1111;
        req_data[0 +: WIDTH] = 32'h5A5A_0001;
        #1;
        check("newdata", fifo_in, 32'h5A5A_0001);
        check("newdata grant", 32'(grant_id), 32'd0);
        tick();
`else
        for (int c = 0; c < 3; c++) expect_beat($sformatf("b0_%0d", c), 0);
        expect_beat("b1_0", 1);
        req_valid = 4'b1101;
        expect_beat("hand2", 2);

        req_valid = 4'b1111;
        fifo_full = 1'b1;
        expect_none("bfull");
        fifo_full = 1'b0;

        rst = 1'b1;
        expect_none("midrst");
        rst = 1'b0;
        for (int c = 0; c < 3; c++) expect_beat($sformatf("post0_%0d", c), 0);
        expect_beat("post1", 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
